// File: rtl/tetris_input_pkg.sv
// tetris_input_pkg: command codes, grant priority order and pending-bit helper shared by the input path.
package tetris_input_pkg;
  localparam int CMD_W = 3;
  localparam int N_CMD = 5;
  typedef enum logic [CMD_W-1:0] {
    CMD_NONE   = 3'd0,
    CMD_LEFT   = 3'd1,
    CMD_RIGHT  = 3'd2,
    CMD_ROTATE = 3'd3,
    CMD_DOWN   = 3'd4,
    CMD_DROP   = 3'd5
  } cmd_t;
  localparam cmd_t PRIO_ORDER [N_CMD] = '{CMD_DROP, CMD_ROTATE, CMD_LEFT, CMD_RIGHT, CMD_DOWN};
  // Pending bit for code c sits at index c-1; NONE has no bit.
  function automatic logic [N_CMD-1:0] cmd_bit(cmd_t c);
    return (c == CMD_NONE) ? '0 : N_CMD'(1) << (int'(c) - 1);
  endfunction
endpackage

// File: rtl/move_cmd_queue_if.sv
// move_cmd_queue_if: key pulses in, valid/ready command stream out; master is the queue side.
interface move_cmd_queue_if import tetris_input_pkg::*; #(parameter int DEPTH = 4);
  logic left_pulse;
  logic right_pulse;
  logic rotate_pulse;
  logic down_pulse;
  logic drop_pulse;
  logic cmd_valid;
  logic cmd_ready;
  cmd_t cmd;
  logic [$clog2(DEPTH):0] level;
  logic overflow;
  modport master (
    input  left_pulse, right_pulse, rotate_pulse, down_pulse, drop_pulse, cmd_ready,
    output cmd_valid, cmd, level, overflow
  );
  modport slave (
    output left_pulse, right_pulse, rotate_pulse, down_pulse, drop_pulse, cmd_ready,
    input  cmd_valid, cmd, level, overflow
  );
endinterface

// File: rtl/cmd_fifo.sv
// cmd_fifo: show-ahead FIFO, power-of-two depth; dout reads zero while empty.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  assign empty   = level == '0;
  assign full    = level == LW'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // Pointers wrap for free since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/move_cmd_queue.sv
// move_cmd_queue: merges key pulses into a prioritised command FIFO with a valid/ready output.
// Define OPPOSITE_CANCEL_EN to make simultaneous left+right pulses cancel each other.
module move_cmd_queue import tetris_input_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  move_cmd_queue_if.master bus
);
  logic [N_CMD-1:0]       pending, pulses, gnt_mask;
  logic [CMD_W-1:0]       head;
  logic [$clog2(DEPTH):0] level;
  logic                   full, empty, pop, can_push, granted, overflow;
  cmd_t                   gnt_code;
`ifdef OPPOSITE_CANCEL_EN
  assign pulses = {bus.drop_pulse, bus.down_pulse, bus.rotate_pulse,
                   bus.right_pulse & ~bus.left_pulse, bus.left_pulse & ~bus.right_pulse};
`else
  assign pulses = {bus.drop_pulse, bus.down_pulse, bus.rotate_pulse, bus.right_pulse, bus.left_pulse};
`endif
  assign pop      = bus.cmd_ready && !empty;
  assign can_push = !full || pop;
  // Walk from lowest to highest priority so the highest pending type wins.
  always_comb begin
    gnt_code = CMD_NONE;
    for (int i = N_CMD - 1; i >= 0; i--)
      gnt_code = ((pending & cmd_bit(PRIO_ORDER[i])) != '0) ? PRIO_ORDER[i] : gnt_code;
  end
  assign granted  = can_push && (gnt_code != CMD_NONE);
  assign gnt_mask = granted ? cmd_bit(gnt_code) : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= (pending & ~gnt_mask) | pulses;
      overflow <= |(pulses & pending & ~gnt_mask);
    end
  cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk(clk), .rst(rst), .push(granted), .pop(pop), .din(gnt_code),
    .dout(head), .level(level), .full(full), .empty(empty)
  );
  assign bus.cmd_valid = !empty;
  assign bus.cmd       = cmd_t'(head);
  assign bus.level     = level;
  assign bus.overflow  = overflow;
endmodule

// File: tb/tb_move_cmd_queue.sv
// tb_move_cmd_queue: scoreboard bench for the key-pulse command queue.
module tb_move_cmd_queue;
  import tetris_input_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;
  int ovf0;
  int sb[$];
  move_cmd_queue_if #(.DEPTH(DEPTH)) bus();
  move_cmd_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // p = {drop, down, rotate, right, left}
  task automatic pulse(input logic [4:0] p);
    {bus.drop_pulse, bus.down_pulse, bus.rotate_pulse, bus.right_pulse, bus.left_pulse} = p;
    tick();
    {bus.drop_pulse, bus.down_pulse, bus.rotate_pulse, bus.right_pulse, bus.left_pulse} = '0;
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (bus.overflow) ovf_cnt++;
      if (bus.cmd_valid && bus.cmd_ready) begin
        check("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) check("cmd_order", 32'(bus.cmd), sb.pop_front());
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    {bus.drop_pulse, bus.down_pulse, bus.rotate_pulse, bus.right_pulse, bus.left_pulse} = '0;
    bus.cmd_ready = 1'b0;
    tick(2);
    check("rst_valid", 32'(bus.cmd_valid), 0);
    check("rst_cmd", 32'(bus.cmd), 0);
    check("rst_level", 32'(bus.level), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    rst = 1'b0;
    // single rotate: visible after second edge
    pulse(5'b00100);
    check("rot_lat1_valid", 32'(bus.cmd_valid), 0);
    tick();
    check("rot_valid", 32'(bus.cmd_valid), 1);
    check("rot_cmd", 32'(bus.cmd), 3);
    check("rot_level", 32'(bus.level), 1);
    sb.push_back(3);
    bus.cmd_ready = 1'b1;
    tick();
    check("rot_pop_valid", 32'(bus.cmd_valid), 0);
    check("rot_pop_level", 32'(bus.level), 0);
    check("rot_pop_cmd", 32'(bus.cmd), 0);
    // all five at once, drained back to back
    sb.push_back(5); sb.push_back(3); sb.push_back(1); sb.push_back(2); sb.push_back(4);
    pulse(5'b11111);
    tick(6);
    check("all5_valid", 32'(bus.cmd_valid), 0);
    check("all5_cmd", 32'(bus.cmd), 0);
    check("all5_sb", 32'(sb.size()), 0);
    // saturate the FIFO with two events left pending
    bus.cmd_ready = 1'b0;
    ovf0 = ovf_cnt;
    sb.push_back(1); sb.push_back(2); sb.push_back(4); sb.push_back(1); sb.push_back(2); sb.push_back(4);
    pulse(5'b00001); pulse(5'b00010); pulse(5'b01000);
    pulse(5'b00001); pulse(5'b00010); pulse(5'b01000);
    tick(2);
    check("sat_level", 32'(bus.level), DEPTH);
    check("sat_head", 32'(bus.cmd), 1);
    check("sat_no_ovf", 32'(ovf_cnt - ovf0), 0);
    bus.cmd_ready = 1'b1;
    tick(8);
    check("sat_drain_level", 32'(bus.level), 0);
    check("sat_drain_sb", 32'(sb.size()), 0);
    // coalesced left while full
    bus.cmd_ready = 1'b0;
    ovf0 = ovf_cnt;
    sb.push_back(5); sb.push_back(3); sb.push_back(2); sb.push_back(4); sb.push_back(1);
    pulse(5'b10000); pulse(5'b00100); pulse(5'b00010); pulse(5'b01000); pulse(5'b00001);
    tick();
    check("ovf_pre", 32'(bus.overflow), 0);
    pulse(5'b00001);
    check("ovf_set", 32'(bus.overflow), 1);
    tick();
    check("ovf_clear", 32'(bus.overflow), 0);
    bus.cmd_ready = 1'b1;
    tick(10);
    check("ovf_drain_level", 32'(bus.level), 0);
    check("ovf_drain_sb", 32'(sb.size()), 0);
    check("ovf_count", 32'(ovf_cnt - ovf0), 1);
    // left and right together
    ovf0 = ovf_cnt;
`ifndef OPPOSITE_CANCEL_EN
    sb.push_back(1); sb.push_back(2);
`endif
    pulse(5'b00011);
    tick(4);
    check("lr_level", 32'(bus.level), 0);
    check("lr_sb", 32'(sb.size()), 0);
    check("lr_no_ovf", 32'(ovf_cnt - ovf0), 0);
    // reset with a partly full queue and pending bits
    bus.cmd_ready = 1'b0;
    pulse(5'b11111);
    tick(3);
    check("prerst_level", 32'(bus.level), 3);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(bus.cmd_valid), 0);
    check("midrst_level", 32'(bus.level), 0);
    check("midrst_cmd", 32'(bus.cmd), 0);
    sb.delete();
    tick();
    rst = 1'b0;
    pulse(5'b01000);
    check("postrst_lat1", 32'(bus.cmd_valid), 0);
    tick();
    check("postrst_valid", 32'(bus.cmd_valid), 1);
    check("postrst_cmd", 32'(bus.cmd), 4);
    sb.push_back(4);
    bus.cmd_ready = 1'b1;
    tick(6);
    check("postrst_level", 32'(bus.level), 0);
    check("postrst_sb", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/move_cmd_queue.md
# move_cmd_queue

Collects the single-cycle key pulses produced by the five per-button auto-repeat handlers and turns them into one ordered stream of game commands. Simultaneous pulses are held, ranked by priority and drained one per cycle into a small show-ahead FIFO. The game logic consumes the FIFO through a valid/ready handshake, so key events are not lost while the playfield FSM is busy. It sits between the input handlers and the piece-movement controller.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- left_pulse  in  1  one-cycle move-left event
- right_pulse  in  1  one-cycle move-right event
- rotate_pulse  in  1  one-cycle rotate event
- down_pulse  in  1  one-cycle soft-drop event
- drop_pulse  in  1  one-cycle hard-drop event
- cmd_valid  out  1  FIFO head holds a command
- cmd_ready  in  1  consumer accepts head this cycle
- cmd  out  3  head command; NONE when cmd_valid=0
- level  out  $clog2(DEPTH)+1  entries currently in FIFO
- overflow  out  1  one-cycle pulse: an event was lost

## Operation
- Command codes: NONE=0, LEFT=1, RIGHT=2, ROTATE=3, DOWN=4, DROP=5; 6, 7 unused.
- Pending register: 5 bits, one per command. Each cycle: pending_next = (pending & ~granted) | pulses.
- Grant: at most one pending bit per cycle, fixed priority DROP > ROTATE > LEFT > RIGHT > DOWN. Granted only when a FIFO push is possible: level<DEPTH, or level==DEPTH with pop this cycle.
- Granted code is written at wr_ptr; wr_ptr increments and wraps at DEPTH.
- Pop: cmd_valid & cmd_ready; rd_ptr increments and wraps. cmd_ready with cmd_valid=0 is ignored.
- Simultaneous push+pop: level unchanged; legal at full and at empty+1.
- Coalescing: a pulse for a type whose pending bit is set and not granted this cycle is merged. overflow pulses high the next cycle. A pulse arriving in the cycle that type is granted re-sets the bit, with no overflow.
- FIFO full with no pop: pending holds; no grant.
- Reset mid-operation discards pending bits and FIFO contents immediately.
- Reset values: cmd_valid=0, cmd=NONE, level=0, overflow=0, pending=0, pointers=0.

## Timing
- Pulse sampled at edge k sets pending. Grant and push occur at edge k+1. cmd_valid=1 after edge k+1, giving 2-cycle latency into an empty queue.
- All five pulses at edge k: pushes at edges k+1..k+5 in order DROP, ROTATE, LEFT, RIGHT, DOWN.
- cmd, cmd_valid and level are registered or derived from registers only; no combinational path from any input.
- Pop at edge j: the next entry appears after edge j, so back-to-back pops sustain 1 command per cycle.
- overflow is registered and asserts for exactly 1 cycle per lost-event cycle.

## Configuration
- OPPOSITE_CANCEL_EN defined: when left_pulse and right_pulse are both high in the same cycle, neither sets pending and overflow is not asserted. Bits already pending are unaffected.
- Not defined: both set pending. LEFT drains before RIGHT.

## Structure
- Shared package tetris_input_pkg holds:
  - cmd_t, a 3-bit enum with the codes above
  - CMD_W=3
  - the priority order as a constant used by the grant logic
- Sub-module cmd_fifo, a parameterised show-ahead FIFO (push, pop, din, dout, level, full, empty). Top level holds pending, grant and overflow logic.

## Test plan
- Reset, then a single rotate_pulse at edge 1 -> cmd_valid=1, cmd=3 after edge 2; cmd_ready=1 at edge 3 -> cmd_valid=0, level=0.
- All five pulses at edge 1, cmd_ready=1 held -> cmd sequence 5, 3, 1, 2, 4 on consecutive cycles, then NONE.
- cmd_ready=0, DEPTH=4, six distinct-cycle left/right/down pulses -> level saturates at 4, two remain pending, no overflow. Raising cmd_ready drains all six in order.
- Queue full, left pending, second left_pulse -> overflow=1 for one cycle, and only one extra LEFT appears.
- left_pulse and right_pulse in the same cycle:
  - OPPOSITE_CANCEL_EN defined -> no command, level stays 0.
  - Not defined -> LEFT then RIGHT.
- rst asserted while level=3 and pending nonzero -> cmd_valid=0, level=0 immediately. After release, the next pulse appears 2 cycles later.
